// File: rtl/multdiv_pkg.sv
// Shared types and opcode decode for the HI/LO multiply/divide sequencer.
// Optional accumulate support is selected with MULTDIV_ACC_EN.
package multdiv_pkg;

  localparam int MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_MADD  = 4'd3,
    MD_MADDU = 4'd4,
    MD_MSUB  = 4'd5,
    MD_MSUBU = 4'd6,
    MD_DIV   = 4'd7,
    MD_DIVU  = 4'd8,
    MD_MTHI  = 4'd9,
    MD_MTLO  = 4'd10
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_WAIT = 3'd1,
    ST_ACC      = 3'd2,
    ST_DIV_WAIT = 3'd3,
    ST_DONE     = 3'd4
  } md_state_t;

  function automatic logic is_mul(input md_op_t op);
    return (op == MD_MULT)  || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB)  || (op == MD_MSUBU);
  endfunction

  function automatic logic is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_acc(input md_op_t op);
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  function automatic logic is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/multdiv_seq_hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
// With MULTDIV_ACC_EN defined it also adds/subtracts a 64-bit product into {hi,lo}.
module hilo_reg (
  input  logic        clk,
  input  logic        rst,
`ifdef MULTDIV_ACC_EN
  input  logic        acc_go,
  input  logic        acc_sub,
  input  logic [63:0] acc_prod,
`endif
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] hi_wd,
  input  logic [31:0] lo_wd,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
`ifdef MULTDIV_ACC_EN
  logic [63:0] acc_sum;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
`ifdef MULTDIV_ACC_EN
    acc_sum = acc_sub ? ({hi_q, lo_q} - acc_prod) : ({hi_q, lo_q} + acc_prod);
    if (acc_go) begin
      {hi_d, lo_d} = acc_sum;
    end
`endif
    if (wr_hi) begin
      hi_d = hi_wd;
    end
    if (wr_lo) begin
      lo_d = lo_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/multdiv_seq.sv
// EXE-stage MULT/DIV sequencer: drives the shared multiplier/divider handshakes and owns HI/LO.
// MULTDIV_ACC_EN enables the MADD/MSUB accumulate state; otherwise those ops overwrite HI/LO.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic [63:0] mul_prod,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_signed,
  output logic        div_abort,
  input  logic        div_done,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem
);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_t           op_req;
  logic             wr_hi, wr_lo;
  logic [31:0]      hi_wd, lo_wd;
  logic             cnt_hit;
`ifdef MULTDIV_ACC_EN
  md_op_t           op_q, op_d;
  logic [63:0]      prod_q, prod_d;
  logic             acc_go;
  logic             acc_sub;

  assign acc_sub = (op_q == MD_MSUB) || (op_q == MD_MSUBU);
`endif

  assign op_req  = md_op_t'(req_op);
  assign cnt_hit = (cnt_q == CNT_W'(MUL_LAT));

  // Start pulses are issued in the request cycle so the product lands exactly when cnt reaches MUL_LAT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    hi_wd      = '0;
    lo_wd      = '0;
    mul_start  = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    mul_signed = 1'b0;
    div_start  = 1'b0;
    div_a      = '0;
    div_b      = '0;
    div_signed = 1'b0;
    div_abort  = 1'b0;
`ifdef MULTDIV_ACC_EN
    op_d       = op_q;
    prod_d     = prod_q;
    acc_go     = 1'b0;
`endif
    stall = ((state_q == ST_IDLE) && req_valid && (is_mul(op_req) || is_div(op_req))) ||
            (state_q == ST_MUL_WAIT) || (state_q == ST_ACC) || (state_q == ST_DIV_WAIT);

    if (rst) begin
      stall = 1'b0;
    end else if (flush) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      div_abort = (state_q == ST_DIV_WAIT);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (is_mul(op_req)) begin
              mul_start  = 1'b1;
              mul_a      = req_a;
              mul_b      = req_b;
              mul_signed = is_signed(op_req);
              cnt_d      = CNT_W'(1);
              state_d    = ST_MUL_WAIT;
`ifdef MULTDIV_ACC_EN
              op_d       = op_req;
`endif
            end else if (is_div(op_req)) begin
              if (req_b != '0) begin
                div_start  = 1'b1;
                div_a      = req_a;
                div_b      = req_b;
                div_signed = is_signed(op_req);
                state_d    = ST_DIV_WAIT;
              end else begin
                state_d = ST_DONE;
              end
            end else if (op_req == MD_MTHI) begin
              wr_hi = 1'b1;
              hi_wd = req_a;
            end else if (op_req == MD_MTLO) begin
              wr_lo = 1'b1;
              lo_wd = req_a;
            end
          end
        end
        ST_MUL_WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_hit) begin
            cnt_d   = '0;
            state_d = ST_DONE;
`ifdef MULTDIV_ACC_EN
            if (is_acc(op_q)) begin
              prod_d  = mul_prod;
              state_d = ST_ACC;
            end else begin
              wr_hi = 1'b1;
              wr_lo = 1'b1;
              hi_wd = mul_prod[63:32];
              lo_wd = mul_prod[31:0];
            end
`else
            wr_hi = 1'b1;
            wr_lo = 1'b1;
            hi_wd = mul_prod[63:32];
            lo_wd = mul_prod[31:0];
`endif
          end
        end
`ifdef MULTDIV_ACC_EN
        ST_ACC: begin
          acc_go  = 1'b1;
          state_d = ST_DONE;
        end
`endif
        ST_DIV_WAIT: begin
          if (div_done) begin
            wr_hi   = 1'b1;
            wr_lo   = 1'b1;
            hi_wd   = div_rem;
            lo_wd   = div_quot;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
`ifdef MULTDIV_ACC_EN
      op_q    <= MD_NOP;
      prod_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef MULTDIV_ACC_EN
      op_q    <= op_d;
      prod_q  <= prod_d;
`endif
    end
  end

  hilo_reg u_hilo (
    .clk      (clk),
    .rst      (rst),
`ifdef MULTDIV_ACC_EN
    .acc_go   (acc_go),
    .acc_sub  (acc_sub),
    .acc_prod (prod_q),
`endif
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .hi_wd    (hi_wd),
    .lo_wd    (lo_wd),
    .hi       (hi),
    .lo       (lo)
  );

endmodule
